// File: rtl/types_pkg.sv
// Shared types for the depth pipeline.
//   pixel_data_t       : rasterizer pixel payload (depth + packed colour)
//   depth_ctrl_state_t : frame life-cycle state of depth_frame_controller
package types_pkg;

  typedef struct packed {
    logic [15:0] depth;
    logic [23:0] color;
  } pixel_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } depth_ctrl_state_t;

endpackage

// File: rtl/addr_sweep_counter.sv
// Parameterised up-counter used for both the Z clear sweep and the drain wait.
//   clk, rstn : clock, asynchronous active-low reset
//   i_start   : force the count back to 0 (has priority over i_en)
//   i_en      : advance the count by one
//   o_count   : current count (registered)
//   o_tc      : count equals LAST_VALUE
// On reaching LAST_VALUE an enabled count returns to 0 rather than running past
// the last value.
module addr_sweep_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LAST_VALUE = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LAST_VALUE);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= '0;
    end else if (i_en) begin
      if (r_count == LAST) r_count <= '0;
      else                 r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/depth_frame_controller.sv
// Per-frame Z-buffer sequencer between the rasterizer and the depth buffer:
// clears every address at frame start, then admits pixel writes, then drains
// the depth-test pipeline before signalling frame done.
//   clk, rstn                     : clock, asynchronous active-low reset
//   frame_start_i / frame_end_i   : single-cycle frame control pulses
//   pix_valid_i/pix_data_i/pix_addr_i, pix_ready_o : rasterizer pixel handshake
//   db_write_*                    : combinational write pass-through to depth buffer
//   db_clear_req_o/db_clear_addr_o: registered clear sweep to depth buffer
//   busy_o, frame_done_o, frame_count_o : status
module depth_frame_controller
  import types_pkg::*;
#(
  parameter int unsigned BUFFER_WIDTH      = 160,
  parameter int unsigned BUFFER_HEIGHT     = 120,
  parameter int unsigned BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
  parameter int unsigned DRAIN_CYCLES      = 3,
  parameter int unsigned FRAME_CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         frame_start_i,
  input  logic                         frame_end_i,
  input  logic                         pix_valid_i,
  output logic                         pix_ready_o,
  input  pixel_data_t                  pix_data_i,
  input  logic [BUFFER_ADDR_WIDTH-1:0] pix_addr_i,
  output logic                         db_write_req_o,
  output pixel_data_t                  db_write_pixel_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] db_write_addr_o,
  output logic                         db_clear_req_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] db_clear_addr_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic [FRAME_CNT_WIDTH-1:0]   frame_count_o
);

  localparam int unsigned NUM_PIX  = BUFFER_WIDTH * BUFFER_HEIGHT;
  localparam int unsigned DRAIN_W  = $clog2(DRAIN_CYCLES + 1);

  depth_ctrl_state_t            r_state;
  logic                         r_pix_ready;
  logic                         r_clear_req;
  logic                         r_busy;
  logic                         r_frame_done;
  logic                         r_pending_start;
  logic [FRAME_CNT_WIDTH-1:0]   r_frame_count;

  logic [BUFFER_ADDR_WIDTH-1:0] w_sweep_count;
  logic                         w_sweep_tc;
  logic [DRAIN_W-1:0]           w_drain_count;
  logic                         w_drain_tc;

  // Counters are held at 0 outside their own state, so entering CLEAR or
  // DRAIN always begins from a zero count without an explicit start pulse.
  addr_sweep_counter #(
    .WIDTH      (BUFFER_ADDR_WIDTH),
    .LAST_VALUE (NUM_PIX - 1)
  ) u_sweep (
    .clk     (clk),
    .rstn    (rstn),
    .i_start (r_state != CLEAR),
    .i_en    (r_state == CLEAR),
    .o_count (w_sweep_count),
    .o_tc    (w_sweep_tc)
  );

  addr_sweep_counter #(
    .WIDTH      (DRAIN_W),
    .LAST_VALUE (DRAIN_CYCLES - 1)
  ) u_drain (
    .clk     (clk),
    .rstn    (rstn),
    .i_start (r_state != DRAIN),
    .i_en    (r_state == DRAIN),
    .o_count (w_drain_count),
    .o_tc    (w_drain_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= IDLE;
      r_pix_ready     <= 1'b0;
      r_clear_req     <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_done    <= 1'b0;
      r_pending_start <= 1'b0;
      r_frame_count   <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frame_start_i) begin
            r_state     <= CLEAR;
            r_clear_req <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        CLEAR: begin
          if (w_sweep_tc) begin
            r_state     <= RUN;
            r_clear_req <= 1'b0;
            r_pix_ready <= 1'b1;
          end
        end
        RUN: begin
          if (frame_start_i || frame_end_i) begin
            r_state         <= DRAIN;
            r_pix_ready     <= 1'b0;
            r_pending_start <= frame_start_i;
          end
        end
        DRAIN: begin
          if (frame_start_i) r_pending_start <= 1'b1;
          if (w_drain_tc) begin
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 1'b1;
            // A start arriving on the final drain cycle is honoured directly.
            if (r_pending_start || frame_start_i) begin
              r_state         <= CLEAR;
              r_clear_req     <= 1'b1;
              r_pending_start <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_pix_ready <= 1'b0;
          r_clear_req <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign pix_ready_o      = r_pix_ready;
  assign db_clear_req_o   = r_clear_req;
  assign db_clear_addr_o  = w_sweep_count;
  assign busy_o           = r_busy;
  assign frame_done_o     = r_frame_done;
  assign frame_count_o    = r_frame_count;

  assign db_write_req_o   = pix_valid_i & r_pix_ready;
  assign db_write_pixel_o = pix_data_i;
  assign db_write_addr_o  = pix_addr_i;

endmodule

// File: tb/tb_depth_frame_controller.sv
module tb_depth_frame_controller;
  import types_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned AW = 3;
  localparam int unsigned FW = 16;

  logic              clk;
  logic              rstn;
  logic              frame_start_i;
  logic              frame_end_i;
  logic              pix_valid_i;
  logic              pix_ready_o;
  pixel_data_t       pix_data_i;
  logic [AW-1:0]     pix_addr_i;
  logic              db_write_req_o;
  pixel_data_t       db_write_pixel_o;
  logic [AW-1:0]     db_write_addr_o;
  logic              db_clear_req_o;
  logic [AW-1:0]     db_clear_addr_o;
  logic              busy_o;
  logic              frame_done_o;
  logic [FW-1:0]     frame_count_o;

  int total;
  int bad;
  int since_write;

  depth_frame_controller #(
    .BUFFER_WIDTH      (W),
    .BUFFER_HEIGHT     (H),
    .BUFFER_ADDR_WIDTH (AW),
    .DRAIN_CYCLES      (3),
    .FRAME_CNT_WIDTH   (FW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .frame_start_i    (frame_start_i),
    .frame_end_i      (frame_end_i),
    .pix_valid_i      (pix_valid_i),
    .pix_ready_o      (pix_ready_o),
    .pix_data_i       (pix_data_i),
    .pix_addr_i       (pix_addr_i),
    .db_write_req_o   (db_write_req_o),
    .db_write_pixel_o (db_write_pixel_o),
    .db_write_addr_o  (db_write_addr_o),
    .db_clear_req_o   (db_clear_req_o),
    .db_clear_addr_o  (db_clear_addr_o),
    .busy_o           (busy_o),
    .frame_done_o     (frame_done_o),
    .frame_count_o    (frame_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clear must never coincide with, or follow within 3 cycles of, a write.
  initial since_write = 100;
  always @(negedge clk) begin
    if (db_write_req_o) since_write = 0;
    else if (since_write < 100) since_write = since_write + 1;
    if (db_clear_req_o) begin
      total = total + 1;
      if (since_write <= 3) begin
        bad = bad + 1;
        $display("FAIL clear_after_write: cycles_since_write=%0d required>3", since_write);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Current cycle is the first CLEAR cycle; checks the 8-address sweep and the
  // first RUN cycle. start_mask pulses frame_start_i during the sweep.
  task automatic check_sweep(input logic [7:0] start_mask);
    for (int i = 0; i < 8; i++) begin
      frame_start_i = start_mask[i];
      pix_valid_i   = 1'b1;
      #1;
      total = total + 1;
      if (db_clear_req_o !== 1'b1 || db_clear_addr_o !== AW'(i) ||
          pix_ready_o !== 1'b0 || db_write_req_o !== 1'b0 || busy_o !== 1'b1) begin
        bad = bad + 1;
        $display("FAIL sweep[%0d]: clr=%b addr=%0d rdy=%b wr=%b busy=%b required clr=1 addr=%0d rdy=0 wr=0 busy=1",
                 i, db_clear_req_o, db_clear_addr_o, pix_ready_o, db_write_req_o, busy_o, i);
      end
      step();
    end
    frame_start_i = 1'b0;
    pix_valid_i   = 1'b0;
    #1;
    total = total + 1;
    if (pix_ready_o !== 1'b1 || db_clear_req_o !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL run_entry: rdy=%b clr=%b required rdy=1 clr=0", pix_ready_o, db_clear_req_o);
    end
  endtask

  // Called in the cycle after the frame_end/frame_start edge; ends in the
  // frame_done cycle.
  task automatic check_drain(input logic [FW-1:0] exp_count, input logic exp_busy);
    for (int d = 0; d < 3; d++) begin
      pix_valid_i = 1'b1;
      #1;
      total = total + 1;
      if (pix_ready_o !== 1'b0 || db_write_req_o !== 1'b0 || db_clear_req_o !== 1'b0 ||
          frame_done_o !== 1'b0 || busy_o !== 1'b1) begin
        bad = bad + 1;
        $display("FAIL drain[%0d]: rdy=%b wr=%b clr=%b done=%b busy=%b required 0 0 0 0 1",
                 d, pix_ready_o, db_write_req_o, db_clear_req_o, frame_done_o, busy_o);
      end
      step();
    end
    pix_valid_i = 1'b0;
    #1;
    total = total + 1;
    if (frame_done_o !== 1'b1 || frame_count_o !== exp_count || busy_o !== exp_busy ||
        pix_ready_o !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL frame_done: done=%b count=%0d busy=%b rdy=%b required done=1 count=%0d busy=%b rdy=0",
               frame_done_o, frame_count_o, busy_o, pix_ready_o, exp_count, exp_busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    frame_start_i = 1'b0;
    frame_end_i = 1'b0;
    pix_valid_i = 1'b0;
    pix_data_i = '0;
    pix_addr_i = '0;
    repeat (3) step();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total = total + 1;
      if ({pix_ready_o, db_clear_req_o, db_write_req_o, busy_o, frame_done_o} !== 5'b0 ||
          frame_count_o !== 16'd0) begin
        bad = bad + 1;
        $display("FAIL reset_idle[%0d]: rdy=%b clr=%b wr=%b busy=%b done=%b count=%0d required all 0",
                 i, pix_ready_o, db_clear_req_o, db_write_req_o, busy_o, frame_done_o, frame_count_o);
      end
    end
  endtask

  task automatic test_run_frame();
    pixel_data_t exp_pix;
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    check_sweep(8'h00);
    for (int j = 0; j < 4; j++) begin
      exp_pix.depth = 16'h1000 + 16'(j * 16'h0111);
      exp_pix.color = 24'hA50000 + 24'(j);
      pix_data_i  = exp_pix;
      pix_addr_i  = 3'd5;
      pix_valid_i = 1'b1;
      frame_end_i = (j == 3);
      #1;
      total = total + 1;
      if (db_write_req_o !== 1'b1 || db_write_addr_o !== 3'd5 || db_write_pixel_o !== exp_pix) begin
        bad = bad + 1;
        $display("FAIL write_fwd[%0d]: wr=%b addr=%0d pix=%h required wr=1 addr=5 pix=%h",
                 j, db_write_req_o, db_write_addr_o, db_write_pixel_o, exp_pix);
      end
      step();
    end
    frame_end_i = 1'b0;
    check_drain(16'd1, 1'b0);
    step();
    total = total + 1;
    if (frame_done_o !== 1'b0 || frame_count_o !== 16'd1 || busy_o !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL after_done: done=%b count=%0d busy=%b required done=0 count=1 busy=0",
               frame_done_o, frame_count_o, busy_o);
    end
  endtask

  task automatic test_start_in_run();
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    check_sweep(8'h00);
    pix_addr_i = 3'd2;
    pix_valid_i = 1'b1;
    step();
    step();
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    check_drain(16'd2, 1'b1);
    check_sweep(8'h00);
    frame_start_i = 1'b1;
    frame_end_i = 1'b1;
    pix_valid_i = 1'b1;
    #1;
    total = total + 1;
    if (db_write_req_o !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL last_write: wr=%b required 1", db_write_req_o);
    end
    step();
    frame_start_i = 1'b0;
    frame_end_i = 1'b0;
    check_drain(16'd3, 1'b1);
    check_sweep(8'h00);
    frame_end_i = 1'b1;
    step();
    frame_end_i = 1'b0;
    check_drain(16'd4, 1'b0);
    step();
  endtask

  task automatic test_start_in_clear();
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    check_sweep(8'b1001_0010);
    frame_end_i = 1'b1;
    step();
    frame_end_i = 1'b0;
    check_drain(16'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      total = total + 1;
      if (busy_o !== 1'b0 || db_clear_req_o !== 1'b0 || frame_done_o !== 1'b0) begin
        bad = bad + 1;
        $display("FAIL no_queued_frame[%0d]: busy=%b clr=%b done=%b required 0 0 0",
                 i, busy_o, db_clear_req_o, frame_done_o);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total = total + 1;
    if (db_clear_req_o !== 1'b1 || db_clear_addr_o !== 3'd3) begin
      bad = bad + 1;
      $display("FAIL pre_reset_addr: clr=%b addr=%0d required clr=1 addr=3", db_clear_req_o, db_clear_addr_o);
    end
    rstn = 1'b0;
    #1;
    total = total + 1;
    if ({pix_ready_o, db_clear_req_o, db_write_req_o, busy_o, frame_done_o} !== 5'b0 ||
        frame_count_o !== 16'd0 || db_clear_addr_o !== 3'd0) begin
      bad = bad + 1;
      $display("FAIL async_reset: rdy=%b clr=%b wr=%b busy=%b done=%b count=%0d addr=%0d required all 0",
               pix_ready_o, db_clear_req_o, db_write_req_o, busy_o, frame_done_o, frame_count_o, db_clear_addr_o);
    end
    step();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total = total + 1;
      if (frame_done_o !== 1'b0 || busy_o !== 1'b0) begin
        bad = bad + 1;
        $display("FAIL post_reset_idle[%0d]: done=%b busy=%b required 0 0", i, frame_done_o, busy_o);
      end
    end
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    check_sweep(8'h00);
    frame_end_i = 1'b1;
    step();
    frame_end_i = 1'b0;
    check_drain(16'd1, 1'b0);
    step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_run_frame();
    test_start_in_run();
    test_start_in_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/depth_frame_controller.md
# depth_frame_controller

Sequencer placed between the rasterizer and the depth buffer. It owns the per-frame life cycle of the Z buffer:
- sweeps every address through the buffer's clear port at frame start;
- admits rasterizer pixel writes only once the clear is complete;
- drains the depth-test pipeline at frame end before reporting the frame done.

It also blocks clear/write overlap, so a pixel still in flight cannot be lost to the buffer's clear-over-write priority.

## Interface
Parameters:
- BUFFER_WIDTH, 160, buffer width in pixels
- BUFFER_HEIGHT, 120, buffer height in pixels
- BUFFER_ADDR_WIDTH, $clog2(BUFFER_WIDTH*BUFFER_HEIGHT), address width
- DRAIN_CYCLES, 3, cycles from the last accepted pixel until its Z write has certainly landed (minimum 3)
- FRAME_CNT_WIDTH, 16, width of the frame counter

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- frame_start_i  in  1  single-cycle pulse requesting a new frame
- frame_end_i  in  1  single-cycle pulse: rasterizer has submitted its last pixel
- pix_valid_i  in  1  rasterizer pixel valid
- pix_ready_o  out  1  controller accepts a pixel this cycle
- pix_data_i  in  pixel_data_t  pixel payload
- pix_addr_i  in  BUFFER_ADDR_WIDTH  pixel buffer address
- db_write_req_o  out  1  to depth buffer write_req
- db_write_pixel_o  out  pixel_data_t  to depth buffer write_pixel
- db_write_addr_o  out  BUFFER_ADDR_WIDTH  to depth buffer write_addr_in
- db_clear_req_o  out  1  to depth buffer clear_req
- db_clear_addr_o  out  BUFFER_ADDR_WIDTH  to depth buffer clear_addr
- busy_o  out  1  state is not IDLE
- frame_done_o  out  1  single-cycle pulse when a frame has fully landed in Z
- frame_count_o  out  FRAME_CNT_WIDTH  number of completed frames (wraps)

## Operation
States:
- IDLE: pix_ready_o=0, no clear.
  - frame_start_i → CLEAR, sweep counter=0.
- CLEAR: db_clear_req_o=1, db_clear_addr_o=sweep counter.
  - Counter increments every cycle.
  - In the cycle where counter = W*H-1 → RUN.
  - frame_start_i is ignored; frame_end_i is ignored.
- RUN: pix_ready_o=1.
  - frame_end_i → DRAIN. The pixel accepted in the same cycle is part of this frame.
  - frame_start_i, alone or together with frame_end_i → DRAIN and set pending_start.
- DRAIN: pix_ready_o=0; drain counter counts DRAIN_CYCLES cycles.
  - On the last count: frame_done pulse is scheduled and frame_count increments.
  - Then → CLEAR if pending_start (pending_start cleared), else → IDLE.
  - frame_start_i during DRAIN sets pending_start.

Write path (combinational):
- db_write_req_o = pix_valid_i & pix_ready_o.
- db_write_pixel_o = pix_data_i; db_write_addr_o = pix_addr_i (pass-through).
- There is no backpressure beyond pix_ready_o; the depth buffer is always ready in RUN.

Invariants:
- db_clear_req_o and db_write_req_o are never high in the same cycle.
- db_clear_req_o is never high within DRAIN_CYCLES cycles after a db_write_req_o.

Arithmetic and limits:
- Sweep counter is BUFFER_ADDR_WIDTH wide and compares against W*H-1; it never wraps past the last address.
- frame_count wraps modulo 2^FRAME_CNT_WIDTH.

Reset:
- Outputs: state IDLE; pix_ready_o, db_clear_req_o, busy_o and frame_done_o = 0; all counters 0; pending_start = 0.
- db_write_req_o is 0 by construction.
- Reset mid-CLEAR or mid-DRAIN aborts immediately with no frame_done pulse. Z contents are then undefined until the next full clear.

## Timing
- frame_start_i sampled at edge k:
  - CLEAR from cycle k+1.
  - db_clear_req_o high for exactly W*H cycles (k+1 … k+W*H), addresses 0 … W*H-1 in order.
  - pix_ready_o high from cycle k+W*H+1.
- frame_end_i sampled at edge e:
  - DRAIN for cycles e+1 … e+DRAIN_CYCLES.
  - frame_done_o high for one cycle at e+DRAIN_CYCLES+1, which is the first IDLE/CLEAR cycle.
  - frame_count_o updates in that same cycle.
- db_clear_req_o, db_clear_addr_o, pix_ready_o, busy_o and frame_done_o are registered, decoded from state and counters with no combinational path from inputs.
- Only the db_write_* outputs are combinational from inputs.

## Structure
- Add a depth_ctrl_state_t enum (IDLE, CLEAR, RUN, DRAIN; 2 bits) to types_pkg.
- pixel_data_t is already in types_pkg.
- No fixed_pkg arithmetic is needed.
- One sub-module, addr_sweep_counter: a parameterised up-counter with start, enable, terminal-count output and last-value parameter. It serves as both the clear sweep counter and the drain counter.

## Test plan
Bench parameters: W=4, H=2 (8 addresses), DRAIN_CYCLES=3.
- Reset, then idle 10 cycles → all outputs 0, busy_o=0, frame_count_o=0.
- frame_start_i at edge 0 → db_clear_req_o high cycles 1–8 with addresses 0–7, pix_ready_o=1 from cycle 9, db_write_req_o=0 throughout.
- RUN, pix_valid_i every cycle with addr 5, then frame_end_i → writes forwarded unchanged; 3 DRAIN cycles with pix_ready_o=0; frame_done_o for 1 cycle; frame_count_o=1; then IDLE.
- frame_start_i in RUN (and in a second run, simultaneous with frame_end_i) → DRAIN 3 cycles, frame_done_o, then a new 8-cycle clear with no idle gap; clear never overlaps or follows within 3 cycles of a write.
- frame_start_i pulses during CLEAR → ignored: exactly one 8-address sweep, no extra frame queued.
- rstn asserted mid-CLEAR at address 3 → outputs 0 immediately, no frame_done_o; a following frame_start_i sweeps again from address 0.
